pulse_period_meter: RTL and testbench

- Measures the spacing, in `clk` cycles, between consecutive rising edges of a single-bit strobe such as a divided-clock enable.
- Reports each measured period with a one-cycle valid pulse, keeps a running edge count, and flags a timeout when the strobe stops.
- Sits on the receive side of the divider/enable path as a self-check and monitor of generated tick rates.

---
 rtl/pulse_period_meter.sv | 94 +++++++++
 tb/tb_pulse_period_meter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures clk-cycle spacing between rising edges of pulse_in, with edge count and timeout.
// Define PULSE_PERIOD_SYNC_EN to pass pulse_in through a two-flop synchronizer first.
module pulse_period_meter #(
    parameter int CNT_W  = 16,
    parameter int EDGE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic              clear,
    output logic [CNT_W-1:0]  period,
    output logic              period_vld,
    output logic              timeout,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_p_d;
    logic             w_p_s;
    logic             w_rise;

`ifdef PULSE_PERIOD_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], pulse_in};
    end

    assign w_p_s = r_sync[1];
`else
    assign w_p_s = pulse_in;
`endif

    assign w_rise = w_p_s & ~r_p_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_p_d      <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
            edge_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            r_p_d      <= w_p_s;
            period_vld <= 1'b0;
            timeout    <= 1'b0;
            // clear discards a coincident rise entirely; period is kept
            if (clear) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                edge_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                if (w_rise) edge_cnt <= edge_cnt + EDGE_W'(1);
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= RUN;
                            r_cnt   <= CNT_W'(1);
                            busy    <= 1'b1;
                        end
                    end
                    RUN: begin
                        // an edge on the saturating cycle wins over timeout
                        if (w_rise) begin
                            period     <= r_cnt;
                            period_vld <= 1'b1;
                            r_cnt      <= CNT_W'(1);
                        end else if (r_cnt == CNT_MAX) begin
                            timeout <= 1'b1;
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter (CNT_W=4 so timeout and saturation are reachable).
module tb_pulse_period_meter;

    localparam int CNT_W  = 4;
    localparam int EDGE_W = 8;
`ifdef PULSE_PERIOD_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              pulse_in;
    logic              clear;
    logic [CNT_W-1:0]  period;
    logic              period_vld;
    logic              timeout;
    logic [EDGE_W-1:0] edge_cnt;
    logic              busy;

    pulse_period_meter #(.CNT_W(CNT_W), .EDGE_W(EDGE_W)) dut (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clear(clear),
        .period(period), .period_vld(period_vld), .timeout(timeout),
        .edge_cnt(edge_cnt), .busy(busy)
    );

    typedef struct {int p; int c;} exp_t;
    exp_t pq[$];
    int   tq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every observed event must match the head of its queue, in value and cycle
    always @(negedge clk) begin
        if (rst_n && period_vld) begin
            checks++;
            if (pq.size() == 0) begin
                failures++;
                $display("FAIL period_vld_unexpected cyc=%0d period=%0d", cyc, period);
            end else begin
                exp_t e;
                e = pq.pop_front();
                if (period !== e.p[CNT_W-1:0] || cyc != e.c) begin
                    failures++;
                    $display("FAIL period got=%0d@%0d exp=%0d@%0d", period, cyc, e.p, e.c);
                end
            end
        end
        if (rst_n && timeout) begin
            checks++;
            if (tq.size() == 0) begin
                failures++;
                $display("FAIL timeout_unexpected cyc=%0d", cyc);
            end else begin
                int t;
                t = tq.pop_front();
                if (cyc != t) begin
                    failures++;
                    $display("FAIL timeout_cycle got=%0d exp=%0d", cyc, t);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // one-cycle strobe; exp_p>0 expects that period, exp_to expects a timeout 15 cycles on
    task automatic strobe(input int exp_p, input bit exp_to = 0);
        exp_t e;
        if (exp_p > 0) begin
            e.p = exp_p;
            e.c = cyc + LAT;
            pq.push_back(e);
        end
        if (exp_to) tq.push_back(cyc + LAT + 15);
        pulse_in = 1;
        tick();
        pulse_in = 0;
    endtask

    task automatic clr();
        idle(2);
        clear = 1;
        tick();
        clear = 0;
        chk("clr_edge_cnt", int'(edge_cnt), 0);
        chk("clr_busy", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1; pulse_in = 0; clear = 0;
        #2 rst_n = 0;
        idle(3);
        chk("rst_period", int'(period), 0);
        chk("rst_vld", int'(period_vld), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1;
        idle(2);

        // period 4: arm, then nine measurements; the last leaves it to time out
        strobe(0);
        idle(3);
        for (int i = 0; i < 9; i++) begin
            strobe(4, i == 8);
            idle(3);
        end
        chk("p4_edge_cnt", int'(edge_cnt), 10);
        chk("p4_busy", int'(busy), 1);
        idle(18);
        chk("to_busy", int'(busy), 0);
        chk("to_period_held", int'(period), 4);
        strobe(0);
        idle(5);
        strobe(6);
        clr();

        // alternating strobe: 256 edges wrap edge_cnt to 0
        strobe(0);
        for (int i = 0; i < 255; i++) begin
            tick();
            strobe(2);
        end
        idle(2);
        chk("alt_edge_wrap", int'(edge_cnt), 0);
        chk("alt_busy", int'(busy), 1);
        clr();

        // edge on the saturating cycle reports max period, no timeout
        strobe(0);
        idle(14);
        strobe(15);
        idle(2);
        chk("max_busy", int'(busy), 1);
        clr();

        // clear coincident with a rise during RUN
        strobe(0);
        idle(3);
        pulse_in = 1;
`ifdef PULSE_PERIOD_SYNC_EN
        tick();
        pulse_in = 0;
        tick();
        clear = 1;
        tick();
`else
        clear = 1;
        tick();
        pulse_in = 0;
`endif
        clear = 0;
        chk("clr_rise_edge_cnt", int'(edge_cnt), 0);
        chk("clr_rise_busy", int'(busy), 0);
        chk("clr_rise_period", int'(period), 15);
        idle(3);
        strobe(0);
        idle(4);
        strobe(5);
        clr();

        // asynchronous reset mid-measurement
        strobe(0);
        idle(3);
        strobe(4);
        idle(3);
        #3 rst_n = 0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_edge_cnt", int'(edge_cnt), 0);
        chk("arst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        strobe(0);
        idle(3);
        strobe(4);
        idle(3);
        chk("post_rst_edge_cnt", int'(edge_cnt), 2);
        clr();

        idle(20);
        chk("pending_periods", pq.size(), 0);
        chk("pending_timeouts", tq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
